// File: rtl/div236_seq_if.sv
// div236_seq_if: request/result bundle between a requester and div236_seq.
//   start   : request pulse, sampled by the divider only while idle
//   operand : W-bit value to classify, captured on the accepting edge
//   busy    : high while bits are being streamed
//   done    : one-cycle pulse when divs is updated
//   divs    : {by2, by3, by6}, held until the next done
interface div236_seq_if #(parameter int W = 16);
    logic         start;
    logic [W-1:0] operand;
    logic         busy;
    logic         done;
    logic [2:0]   divs;
    modport master (output start, operand, input busy, done, divs);
    modport slave  (input start, operand, output busy, done, divs);
endinterface

// File: rtl/div236_seq.sv
// div236_seq: bit-serial divisibility-by-2/3/6 classifier for a W-bit operand.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : div236_seq_if slave (start/operand in, busy/done/divs out)
module div236_seq #(
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          rst,
    div236_seq_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  sr;
    logic          lsb;
    logic [1:0]    rem;
    logic [1:0]    rem_next;
    logic [CW-1:0] cnt;
    logic          bit_in;

    // Running mod-3 remainder of the MSB-first prefix: rem' = (2*rem + bit) mod 3.
    always_comb begin
        bit_in   = sr[W-1];
        rem_next = (rem == 2'd0) ? {1'b0, bit_in} :
                   (rem == 2'd1) ? (bit_in ? 2'd0 : 2'd2) :
                                   (bit_in ? 2'd2 : 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.divs <= 3'b000;
            rem      <= 2'd0;
            cnt      <= '0;
            sr       <= '0;
            lsb      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sr       <= bus.operand;
                        lsb      <= bus.operand[0];
                        rem      <= 2'd0;
                        cnt      <= CW'(W - 1);
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    sr  <= {sr[W-2:0], 1'b0};
                    if (cnt == '0) begin
                        // Final bit: publish using the remainder that includes it.
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.divs <= {~lsb, rem_next == 2'd0, ~lsb & (rem_next == 2'd0)};
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div236_seq.sv
// tb_div236_seq: self-checking bench for div236_seq at W=16 and W=4.
//   Expected divs are queued when a start is driven and compared when done rises.
module tb_div236_seq;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div236_seq_if #(.W(16)) a16 ();
    div236_seq_if #(.W(4))  a4 ();

    div236_seq #(.W(16)) d16 (.clk(clk), .rst(rst), .bus(a16));
    div236_seq #(.W(4))  d4  (.clk(clk), .rst(rst), .bus(a4));

    typedef struct {
        logic [15:0] op;
        logic [2:0]  exp;
    } vec_t;

    vec_t       vecs [8];
    logic [2:0] q16 [$];
    logic [2:0] q4 [$];
    logic [2:0] prev16, prev4;
    logic       prev_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    // Scoreboards: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        chk("busy_done_overlap16", {31'd0, a16.busy & a16.done}, 32'd0);
        chk("busy_done_overlap4", {31'd0, a4.busy & a4.done}, 32'd0);
        if (a16.done) begin
            if (q16.size() == 0) chk("done16_unexpected", 32'd1, 32'd0);
            else chk("divs16", {29'd0, a16.divs}, {29'd0, q16.pop_front()});
        end
        if (a4.done) begin
            if (q4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
            else chk("divs4", {29'd0, a4.divs}, {29'd0, q4.pop_front()});
        end
        if (!rst && !prev_rst) begin
            if (!a16.done && a16.divs !== prev16) chk("divs16_hold", {29'd0, a16.divs}, {29'd0, prev16});
            if (!a4.done && a4.divs !== prev4) chk("divs4_hold", {29'd0, a4.divs}, {29'd0, prev4});
        end
        prev16   = a16.divs;
        prev4    = a4.divs;
        prev_rst = rst;
    end

    // pa/pb: RUN cycles at which a stray start (operand 7) is pulsed; ra: RUN cycle to reset at.
    task automatic run16(input logic [15:0] op, input logic [2:0] exp, input int pa, input int pb, input int ra);
        int lat = 0;
        int bc = 0;
        @(negedge clk);
        a16.operand = op;
        a16.start   = 1'b1;
        q16.push_back(exp);
        @(posedge clk);
        #1;
        a16.start   = 1'b0;
        a16.operand = 16'($urandom);
        do begin
            if (a16.busy) bc++;
            a16.start = (lat == pa || lat == pb);
            if (a16.start) a16.operand = 16'd7;
            if (lat == ra) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst       = 1'b0;
                a16.start = 1'b0;
                q16.delete();
                chk("rst_busy", {31'd0, a16.busy}, 32'd0);
                chk("rst_done", {31'd0, a16.done}, 32'd0);
                chk("rst_divs", {29'd0, a16.divs}, 32'd0);
                return;
            end
            @(posedge clk);
            #1;
            lat++;
        end while (!a16.done && lat < 40);
        a16.start = 1'b0;
        chk("lat16", lat, 16);
        chk("busy16_cycles", bc, 16);
        @(posedge clk);
        #1;
        chk("done16_width", {31'd0, a16.done}, 32'd0);
    endtask

    task automatic run4(input logic [3:0] op, input logic [2:0] exp);
        int lat = 0;
        int bc = 0;
        @(negedge clk);
        a4.operand = op;
        a4.start   = 1'b1;
        q4.push_back(exp);
        @(posedge clk);
        #1;
        a4.start   = 1'b0;
        a4.operand = 4'($urandom);
        do begin
            if (a4.busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end while (!a4.done && lat < 20);
        chk("lat4", lat, 4);
        chk("busy4_cycles", bc, 4);
        @(posedge clk);
        #1;
        chk("done4_width", {31'd0, a4.done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'd0,     3'b111};
        vecs[1] = '{16'd6,     3'b111};
        vecs[2] = '{16'd9,     3'b010};
        vecs[3] = '{16'd10,    3'b100};
        vecs[4] = '{16'd11,    3'b000};
        vecs[5] = '{16'hFFFF,  3'b010};
        vecs[6] = '{16'hFFFE,  3'b100};
        vecs[7] = '{16'd30000, 3'b111};
        rst = 1'b1;
        a16.start = 1'b0;
        a16.operand = '0;
        a4.start = 1'b0;
        a4.operand = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy16", {31'd0, a16.busy}, 32'd0);
        chk("reset_done16", {31'd0, a16.done}, 32'd0);
        chk("reset_divs16", {29'd0, a16.divs}, 32'd0);
        chk("reset_divs4", {29'd0, a4.divs}, 32'd0);
        for (int i = 0; i < 8; i++) run16(vecs[i].op, vecs[i].exp, -1, -1, -1);
        run16(16'd12, 3'b111, 3, 10, -1);
        repeat (20) @(posedge clk);
        run16(16'd6, 3'b111, -1, -1, 5);
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_divs", {29'd0, a16.divs}, 32'd0);
        run16(16'd3, 3'b010, -1, -1, -1);
        for (int v = 0; v < 16; v++)
            run4(4'(v), {v % 2 == 0, v % 3 == 0, v % 6 == 0});
        repeat (5) @(posedge clk);
        #1;
        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
